router_port: RTL and testbench

ROUTER_PORT -- requirements
Module: router_port

---
 rtl/router_pkg.sv | 27 ++
 rtl/pkt_fifo.sv | 48 ++++
 rtl/router_port.sv | 140 ++++++++++++++
 tb/tb_router_port.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared packet type, wire-format constants and byte-select helper for the router port.
// Optional ROUTER_PORT_STATS_EN build adds packet counters in router_port.
package router_pkg;
   localparam int PKT_BYTES = 4;
   localparam int BYTE_W    = 8;

   typedef struct packed {
      logic [3:0]  src_id;
      logic [3:0]  dest_id;
      logic [23:0] data;
   } pkt_t;

   typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

   // Byte idx of the wire format: 0 = {src,dest}, 3 = data[7:0].
   function automatic logic [BYTE_W-1:0] pkt_byte(input pkt_t p, input logic [1:0] idx);
      logic [PKT_BYTES*BYTE_W-1:0] w;
      w = p;
      case (idx)
         2'd0:    return w[31:24];
         2'd1:    return w[23:16];
         2'd2:    return w[15:8];
         default: return w[7:0];
      endcase
   endfunction
endpackage

// File: rtl/pkt_fifo.sv
// Received-packet FIFO; power-of-two depth so pointers wrap naturally.
module pkt_fifo
   import router_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  pkt_t        din,
   input  logic        pop,
   output pkt_t        dout,
   output logic        full,
   output logic        empty,
   output logic [AW:0] count
);
   pkt_t          mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic          do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is only taken when a pop frees the slot the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? pkt_t'('0) : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/router_port.sv
// Endpoint-side router port: byte-serial RX assembly into a FIFO, TX serialisation.
// Define ROUTER_PORT_STATS_EN to add rx_count/tx_count packet counters.
module router_port
   import router_pkg::*;
#(
   parameter int RX_DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   output logic       free_outbound,
   input  logic       put_outbound,
   input  logic [7:0] payload_outbound,
   input  logic       free_inbound,
   output logic       put_inbound,
   output logic [7:0] payload_inbound,
   output pkt_t       rx_pkt,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  pkt_t       tx_pkt,
   input  logic       tx_valid,
   output logic       tx_ready
`ifdef ROUTER_PORT_STATS_EN
   ,
   output logic [7:0] rx_count,
   output logic [7:0] tx_count
`endif
);
   localparam int CW = $clog2(RX_DEPTH);

   logic        up;
   rx_state_t   rx_state, rx_next;
   logic [1:0]  rx_idx;
   logic [31:0] rx_asm;
   logic        rx_push, rx_accept, rx_space;
   logic        fifo_full, fifo_empty;
   logic [CW:0] fifo_count;

   tx_state_t   tx_state, tx_next;
   logic [1:0]  tx_idx;
   pkt_t        tx_buf;
   logic        tx_accept, tx_last;

   // Holds the handshakes low until the first edge after reset releases.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) up <= 1'b0;
      else     up <= 1'b1;
   end

   // A packet waiting to be pushed already owns a slot.
   assign rx_space      = !fifo_full && !(rx_push && fifo_count == (CW+1)'(RX_DEPTH-1));
   assign free_outbound = up && (rx_state == RX_IDLE) && rx_space;
   assign rx_accept     = free_outbound && put_outbound;

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE: if (rx_accept) rx_next = RX_RECV;
         RX_RECV: if (rx_idx == 2'd3) rx_next = RX_IDLE;
         default: rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         rx_idx   <= '0;
         rx_asm   <= '0;
         rx_push  <= 1'b0;
      end else begin
         rx_state <= rx_next;
         rx_push  <= (rx_state == RX_RECV) && (rx_idx == 2'd3);
         if (rx_accept) begin
            rx_asm <= {24'h0, payload_outbound};
            rx_idx <= 2'd1;
         end else if (rx_state == RX_RECV) begin
            rx_asm <= {rx_asm[23:0], payload_outbound};
            rx_idx <= rx_idx + 1'b1;
         end
      end
   end

   pkt_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .din   (pkt_t'(rx_asm)),
      .pop   (rx_ready),
      .dout  (rx_pkt),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign rx_valid = !fifo_empty;

   assign tx_ready  = up && (tx_state == TX_IDLE) && free_inbound;
   assign tx_accept = tx_valid && tx_ready;
   assign tx_last   = (tx_state == TX_SEND) && (tx_idx == 2'd3);

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE: if (tx_accept) tx_next = TX_SEND;
         TX_SEND: if (tx_idx == 2'd3) tx_next = TX_IDLE;
         default: tx_next = TX_IDLE;
      endcase
   end

   // free_inbound is not looked at once SEND starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_idx   <= '0;
         tx_buf   <= '0;
      end else begin
         tx_state <= tx_next;
         if (tx_accept) begin
            tx_buf <= tx_pkt;
            tx_idx <= '0;
         end else if (tx_state == TX_SEND) begin
            tx_idx <= tx_idx + 1'b1;
         end
      end
   end

   assign put_inbound     = (tx_state == TX_SEND) && (tx_idx == 2'd0);
   assign payload_inbound = (tx_state == TX_SEND) ? pkt_byte(tx_buf, tx_idx) : 8'h00;

`ifdef ROUTER_PORT_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_count <= '0;
         tx_count <= '0;
      end else begin
         if (rx_push) rx_count <= rx_count + 1'b1;
         if (tx_last) tx_count <= tx_count + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_router_port.sv
// Directed bench for router_port with RX/TX scoreboards; stats checks when ROUTER_PORT_STATS_EN is set.
module tb_router_port;
   import router_pkg::*;

   logic       clk, rst;
   logic       free_outbound, put_outbound;
   logic [7:0] payload_outbound;
   logic       free_inbound, put_inbound;
   logic [7:0] payload_inbound;
   pkt_t       rx_pkt, tx_pkt;
   logic       rx_valid, rx_ready, tx_valid, tx_ready;
`ifdef ROUTER_PORT_STATS_EN
   logic [7:0] rx_count, tx_count;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] rx_q[$];
   logic [7:0]  tx_q[$];

   router_port #(.RX_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .free_outbound(free_outbound), .put_outbound(put_outbound),
      .payload_outbound(payload_outbound),
      .free_inbound(free_inbound), .put_inbound(put_inbound),
      .payload_inbound(payload_inbound),
      .rx_pkt(rx_pkt), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_pkt(tx_pkt), .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef ROUTER_PORT_STATS_EN
      , .rx_count(rx_count), .tx_count(tx_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after B3 has been sampled.
   task automatic send_rx(input logic [31:0] p);
      int n = 0;
      while (!free_outbound && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("rx_free_timeout", {31'b0, free_outbound}, 32'd1);
      rx_q.push_back(p);
      put_outbound = 1'b1; payload_outbound = p[31:24];
      @(negedge clk); put_outbound = 1'b0; payload_outbound = p[23:16];
      @(negedge clk); payload_outbound = p[15:8];
      @(negedge clk); payload_outbound = p[7:0];
      @(negedge clk); payload_outbound = 8'h00;
   endtask

   task automatic pop_rx(input string tag);
      int n = 0;
      logic [31:0] e;
      while (!rx_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      e = rx_q.pop_front();
      chk(tag, rx_pkt, e);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic push_tx(input logic [31:0] p);
      tx_q.push_back(p[31:24]);
      tx_q.push_back(p[23:16]);
      tx_q.push_back(p[15:8]);
      tx_q.push_back(p[7:0]);
   endtask

   task automatic tx_collect(input string tag);
      int n = 0;
      logic [7:0] e;
      while (!put_inbound && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 4; k++) begin
         e = tx_q.pop_front();
         chk({tag, "_byte"}, {24'b0, payload_inbound}, {24'b0, e});
         chk({tag, "_put"}, {31'b0, put_inbound}, (k == 0) ? 32'd1 : 32'd0);
         chk({tag, "_ready_low"}, {31'b0, tx_ready}, 32'd0);
         @(negedge clk);
      end
      chk({tag, "_idle_put"}, {31'b0, put_inbound}, 32'd0);
      chk({tag, "_idle_payload"}, {24'b0, payload_inbound}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; put_outbound = 1'b0; payload_outbound = 8'h00;
      free_inbound = 1'b1; rx_ready = 1'b0; tx_pkt = '0; tx_valid = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_free_out", {31'b0, free_outbound}, 32'd0);
      chk("rst_put_in", {31'b0, put_inbound}, 32'd0);
      chk("rst_payload_in", {24'b0, payload_inbound}, 32'd0);
      chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
      chk("rst_tx_ready", {31'b0, tx_ready}, 32'd0);
      chk("rst_rx_pkt", rx_pkt, 32'd0);
      rst = 1'b0;
      #1 chk("free_before_edge", {31'b0, free_outbound}, 32'd0);
      @(negedge clk);
      chk("free_after_edge", {31'b0, free_outbound}, 32'd1);

      // RX basic with latency
      send_rx(32'hF0AAAAAA);
      chk("rx_lat_b3", {31'b0, rx_valid}, 32'd0);
      @(negedge clk);
      chk("rx_lat_b4", {31'b0, rx_valid}, 32'd1);
      pop_rx("rx_basic");
      chk("rx_empty", {31'b0, rx_valid}, 32'd0);

      // RX backpressure
      send_rx(32'hF0AAAAAA);
      send_rx(32'h12345678);
      chk("bp_free_low", {31'b0, free_outbound}, 32'd0);
      put_outbound = 1'b1; payload_outbound = 8'h55;
      @(negedge clk); put_outbound = 1'b0; payload_outbound = 8'h66;
      @(negedge clk); payload_outbound = 8'h77;
      @(negedge clk); payload_outbound = 8'h88;
      @(negedge clk); payload_outbound = 8'h00;
      repeat (3) @(negedge clk);
      chk("bp_free_still_low", {31'b0, free_outbound}, 32'd0);
      chk("bp_head", rx_pkt, rx_q[0]);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      void'(rx_q.pop_front());
      chk("bp_free_back", {31'b0, free_outbound}, 32'd1);
      pop_rx("bp_second");
      chk("bp_third_ignored", {31'b0, rx_valid}, 32'd0);

      // TX basic
      tx_pkt = 32'h0F123456; tx_valid = 1'b1;
      push_tx(32'h0F123456);
      #1 chk("tx_ready_idle", {31'b0, tx_ready}, 32'd1);
      @(negedge clk); tx_valid = 1'b0;
      tx_collect("tx_basic");

      // TX hold-off, then free_inbound drops mid-SEND
      free_inbound = 1'b0; tx_pkt = 32'hA1B2C3D4; tx_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("hold_put", {31'b0, put_inbound}, 32'd0);
         chk("hold_ready", {31'b0, tx_ready}, 32'd0);
      end
      free_inbound = 1'b1;
      push_tx(32'hA1B2C3D4);
      @(negedge clk); free_inbound = 1'b0; tx_valid = 1'b0;
      tx_collect("tx_hold");
      chk("hold_ready_after", {31'b0, tx_ready}, 32'd0);
      free_inbound = 1'b1;

      // Reset mid-packet on both RX and TX
      put_outbound = 1'b1; payload_outbound = 8'h3C;
      tx_pkt = 32'hDEADBEEF; tx_valid = 1'b1;
      @(negedge clk); put_outbound = 1'b0; payload_outbound = 8'h11; tx_valid = 1'b0;
      @(negedge clk); rst = 1'b1; payload_outbound = 8'h00;
      #1;
      chk("mid_rst_free", {31'b0, free_outbound}, 32'd0);
      chk("mid_rst_put_in", {31'b0, put_inbound}, 32'd0);
      chk("mid_rst_payload_in", {24'b0, payload_inbound}, 32'd0);
      @(negedge clk); @(negedge clk); rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("mid_rst_no_partial", {31'b0, rx_valid}, 32'd0);
      chk("mid_rst_tx_idle", {31'b0, put_inbound}, 32'd0);
      send_rx(32'h3C5A6B7C);
      pop_rx("after_rst");

`ifdef ROUTER_PORT_STATS_EN
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("stats_rst_rx", {24'b0, rx_count}, 32'd0);
      tx_pkt = 32'h01020304; tx_valid = 1'b1;
      push_tx(32'h01020304);
      @(negedge clk); tx_valid = 1'b0;
      tx_collect("stats_tx");
      chk("stats_tx_count", {24'b0, tx_count}, 32'd1);
      rx_ready = 1'b1;
      for (int i = 0; i < 257; i++) send_rx(32'h10000000 | i);
      repeat (3) @(negedge clk);
      rx_ready = 1'b0;
      rx_q.delete();
      chk("stats_rx_wrap", {24'b0, rx_count}, 32'd1);
      chk("stats_drained", {31'b0, rx_valid}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
